// File: rtl/axis_join_pkg.sv
// Shared definitions for the AXI-Stream fork/join pair: default widths and
// the lane slice helper that fixes where lane i sits on a packed bus.
package axis_join_pkg;

  localparam int DEF_DATA_WD = 32;
  localparam int DEF_CNT_WD  = 16;

  // Lane i occupies bits [lane_lsb(i, wd) +: wd] of a packed multi-lane bus.
  function automatic int lane_lsb(input int lane, input int data_wd);
    return lane * data_wd;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry main/skid output register: fully registered master side, and
// in_ready is derived from skid occupancy only (no combinational out_ready path).
module axis_skid_buf
  import axis_join_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_DATA_WD + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (main_valid_q && out_ready) begin
      // in_valid cannot coincide with a full skid because in_ready is low then.
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_valid) begin
        main_data_d = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_valid) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/axis_stream_join.sv
// Joins N_IN AXI-Stream lanes into one wide beat: all lanes handshake together,
// the joined beat goes through a main/skid register, and end-of-packet agreement is checked.
module axis_stream_join
  import axis_join_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int DATA_WD = DEF_DATA_WD,
  parameter int CNT_WD  = DEF_CNT_WD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         s_valid,
  output logic [N_IN-1:0]         s_ready,
  input  logic [N_IN*DATA_WD-1:0] s_data,
  input  logic [N_IN-1:0]         s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_IN*DATA_WD-1:0] m_data,
  output logic                    m_last,
  output logic                    err_last,
  output logic [CNT_WD-1:0]       pkt_cnt
);

  localparam int BUS_WD = N_IN * DATA_WD;

  logic [BUS_WD-1:0] join_data;
  logic              all_valid;
  logic              can_accept;
  logic              fire;
  logic              last_all;
  logic              last_any;
  logic              err_last_q, err_last_d;
  logic [CNT_WD-1:0] pkt_cnt_q, pkt_cnt_d;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
    assign join_data[lane_lsb(gi, DATA_WD) +: DATA_WD] = s_data[lane_lsb(gi, DATA_WD) +: DATA_WD];
  end

  // Lanes may see ready depend on their own valid: no lane waits on ready before asserting valid.
  assign all_valid = &s_valid;
  assign fire      = !rst && all_valid && can_accept;
  assign s_ready   = {N_IN{fire}};
  assign last_all  = &s_last;
  assign last_any  = |s_last;

  axis_skid_buf #(
    .WIDTH(BUS_WD + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (fire),
    .in_data  ({last_all, join_data}),
    .in_ready (can_accept),
    .out_valid(m_valid),
    .out_data ({m_last, m_data}),
    .out_ready(m_ready)
  );

  always_comb begin
    err_last_d = fire && last_any && !last_all;
    pkt_cnt_d  = pkt_cnt_q;
    if (m_valid && m_ready && m_last) begin
      pkt_cnt_d = pkt_cnt_q + CNT_WD'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_last_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      err_last_q <= err_last_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign err_last = err_last_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_axis_stream_join.sv
// Self-checking bench for axis_stream_join (N_IN=2, CNT_WD=4): directed steps plus random
// traffic, compared each cycle against a queue-based reference of the joined stream.
module tb_axis_stream_join;

  localparam int N_IN    = 2;
  localparam int DATA_WD = 32;
  localparam int CNT_WD  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_IN-1:0]         s_valid;
  logic [N_IN-1:0]         s_ready;
  logic [N_IN*DATA_WD-1:0] s_data;
  logic [N_IN-1:0]         s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic [N_IN*DATA_WD-1:0] m_data;
  logic                    m_last;
  logic                    err_last;
  logic [CNT_WD-1:0]       pkt_cnt;

  axis_stream_join #(.N_IN(N_IN), .DATA_WD(DATA_WD), .CNT_WD(CNT_WD)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .err_last(err_last), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t q[$];          // beats joined but not yet handed downstream, oldest first
  int    cnt_exp  = 0;  // joined packets seen downstream, modulo 2^CNT_WD
  logic  err_exp  = 1'b0;
  int    n_out    = 0;
  int    n_assert = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the reference, advance the reference.
  task automatic cycle(input logic [1:0] v, input logic [63:0] d, input logic [1:0] l,
                       input logic mr, input logic r);
    logic  exp_fire;
    logic  take;
    beat_t b;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = mr;
    rst     = r;
    #1;
    exp_fire = !r && (v == 2'b11) && (q.size() < 2);
    chk("s_ready", 64'(s_ready), 64'({2{exp_fire}}));
    chk("m_valid", 64'(m_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("m_data", m_data, q[0].d);
      chk("m_last", 64'(m_last), 64'(q[0].l));
    end
    chk("err_last", 64'(err_last), 64'(err_exp));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(cnt_exp));
    take = (q.size() > 0) && mr;
    $display("t=%0t rst=%0b v=%b l=%b mr=%0b fire=%0b m_valid=%0b m_data=%h pkt_cnt=%0d",
             $time, r, v, l, mr, exp_fire, m_valid, m_data, pkt_cnt);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      cnt_exp = 0;
      err_exp = 1'b0;
    end else begin
      if (take) begin
        if (q[0].l) cnt_exp = (cnt_exp + 1) % (1 << CNT_WD);
        void'(q.pop_front());
        n_out++;
      end
      if (exp_fire) begin
        b.d = d;
        b.l = &l;
        q.push_back(b);
      end
      err_exp = exp_fire && (l != 2'b00) && (l != 2'b11);
    end
  endtask

  initial begin
    int base;
    s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset held with both lanes valid: s_ready must stay low, outputs at reset values.
    cycle(2'b11, 64'h1, 2'b11, 1'b1, 1'b1);
    chk("reset_m_data", m_data, 64'h0);
    chk("reset_m_last", 64'(m_last), 64'h0);

    // Lane 0 valid first, lane 1 three cycles later.
    cycle(2'b01, 64'h00000000_00000011, 2'b00, 1'b1, 1'b0);
    cycle(2'b01, 64'h00000000_00000011, 2'b00, 1'b1, 1'b0);
    cycle(2'b01, 64'h00000000_00000011, 2'b00, 1'b1, 1'b0);
    cycle(2'b11, 64'h00000022_00000011, 2'b00, 1'b1, 1'b0);
    chk("join_m_data", m_data, 64'h00000022_00000011);
    chk("join_m_valid", 64'(m_valid), 64'h1);
    cycle(2'b00, 64'h0, 2'b00, 1'b1, 1'b0);
    chk("join_one_cycle", 64'(m_valid), 64'h0);

    // 100 back-to-back beats, lane data = index.
    base = n_out;
    for (int i = 0; i < 100; i++) cycle(2'b11, {32'(i), 32'(i)}, 2'b00, 1'b1, 1'b0);
    repeat (2) cycle(2'b00, 64'h0, 2'b00, 1'b1, 1'b0);
    chk("stream_100_count", 64'(n_out - base), 64'd100);

    // Backpressure: m_ready low for 5 cycles mid-stream.
    for (int i = 0; i < 4; i++) cycle(2'b11, {32'(i + 200), 32'(i + 300)}, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(2'b11, {32'(i + 400), 32'(i + 500)}, 2'b00, 1'b0, 1'b0);
    chk("bp_held_ready", 64'(s_ready), 64'h0);
    for (int i = 0; i < 6; i++) cycle(2'b11, {32'(i + 600), 32'(i + 700)}, 2'b00, 1'b1, 1'b0);
    repeat (3) cycle(2'b00, 64'h0, 2'b00, 1'b1, 1'b0);

    // Last disagreement and agreement.
    cycle(2'b11, 64'hAAAA_0001, 2'b01, 1'b1, 1'b0);
    chk("mismatch_m_last", 64'(m_last), 64'h0);
    chk("mismatch_err", 64'(err_last), 64'h1);
    cycle(2'b11, 64'hAAAA_0002, 2'b11, 1'b1, 1'b0);
    chk("match_m_last", 64'(m_last), 64'h1);
    chk("err_one_cycle", 64'(err_last), 64'h0);
    repeat (2) cycle(2'b00, 64'h0, 2'b00, 1'b1, 1'b0);

    // Counter wrap: reset, then 16 packets -> 0, 17th -> 1.
    cycle(2'b00, 64'h0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cycle(2'b11, 64'(i), 2'b11, 1'b1, 1'b0);
    repeat (2) cycle(2'b00, 64'h0, 2'b00, 1'b1, 1'b0);
    chk("wrap_after_16", 64'(pkt_cnt), 64'h0);
    cycle(2'b11, 64'h17, 2'b11, 1'b1, 1'b0);
    repeat (2) cycle(2'b00, 64'h0, 2'b00, 1'b1, 1'b0);
    chk("wrap_after_17", 64'(pkt_cnt), 64'h1);

    // Reset with main and skid both full; beats are lost, next beat has latency 1.
    for (int i = 0; i < 3; i++) cycle(2'b11, 64'(i + 900), 2'b11, 1'b0, 1'b0);
    cycle(2'b11, 64'h999, 2'b11, 1'b0, 1'b1);
    chk("rst_full_m_valid", 64'(m_valid), 64'h0);
    chk("rst_full_pkt_cnt", 64'(pkt_cnt), 64'h0);
    cycle(2'b11, 64'h1234_5678_9ABC_DEF0, 2'b00, 1'b1, 1'b0);
    chk("post_rst_latency", m_data, 64'h1234_5678_9ABC_DEF0);
    repeat (2) cycle(2'b00, 64'h0, 2'b00, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle({1'($urandom % 4 != 0), 1'($urandom % 4 != 0)}, {$urandom, $urandom},
            2'($urandom), 1'($urandom % 3 != 0), 1'($urandom % 97 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
